// File: rtl/phased_tx_pkg.sv
// Purpose : shared types and default widths for the phased-array transmit scheduler.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package phased_tx_pkg;

   localparam int NUM_CH_DEF  = 8;
   localparam int DLY_W_DEF   = 12;
   localparam int HALF_W_DEF  = 12;
   localparam int PULSE_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // One delay-table entry; entry width is the package default delay width.
   typedef struct packed {
      logic [DLY_W_DEF-1:0] delay;
   } channel_cfg_t;

endpackage

// File: rtl/phased_tx_scheduler_channel.sv
// Purpose : one transducer channel; waits for t==delay, then emits P square pulses of half-period H.
// Latency : tx is registered; it is high in the cycle whose timebase equals the delay.
// Backpressure : none; free-running once started, cleared by kill or when go drops.
// Ports   : go = next cycle is a RUN cycle, t = timebase value of the next cycle,
//           delay/H/P = burst parameters, kill = abort; tx = drive, finished = done after this edge.
module phased_tx_channel #(
   parameter int DLY_W   = 12,
   parameter int HALF_W  = 12,
   parameter int PULSE_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               go,
   input  logic [DLY_W:0]     t,
   input  logic [DLY_W-1:0]   delay,
   input  logic [HALF_W-1:0]  H,
   input  logic [PULSE_W-1:0] P,
   input  logic               kill,
   output logic               tx,
   output logic               finished
);

   logic               started_q;
   logic               fin_q;
   logic               tx_q;
   logic [HALF_W-1:0]  hcnt_q;   // cycles spent in the current half, 1..H
   logic [PULSE_W-1:0] pcnt_q;   // completed pulses
   logic               last_edge;

   // End of the final low half: the channel is finished from the next cycle on.
   // Exposed combinationally so the scheduler can leave RUN on the same edge.
   assign last_edge = started_q && !fin_q && !tx_q && (hcnt_q == H) &&
                      (pcnt_q == P - PULSE_W'(1));
   assign finished  = fin_q | last_edge;
   assign tx        = tx_q;

   always_ff @(posedge clock) begin
      if (reset || kill || !go) begin
         started_q <= 1'b0;
         fin_q     <= 1'b0;
         tx_q      <= 1'b0;
         hcnt_q    <= '0;
         pcnt_q    <= '0;
      end else if (!started_q) begin
         if (t == {1'b0, delay}) begin
            started_q <= 1'b1;
            tx_q      <= 1'b1;
            hcnt_q    <= HALF_W'(1);
            pcnt_q    <= '0;
         end
      end else if (!fin_q) begin
         if (hcnt_q == H) begin
            hcnt_q <= HALF_W'(1);
            if (tx_q) begin
               tx_q <= 1'b0;
            end else if (last_edge) begin
               fin_q <= 1'b1;
            end else begin
               pcnt_q <= pcnt_q + PULSE_W'(1);
               tx_q   <= 1'b1;
            end
         end else begin
            hcnt_q <= hcnt_q + HALF_W'(1);
         end
      end
   end

endmodule

// File: rtl/phased_tx_scheduler.sv
// Purpose : fires a steered burst on all channels using a shadowed per-channel delay table.
// Latency : busy one cycle after start, first RUN cycle two cycles after start, done one cycle after the last channel finishes.
// Backpressure : none; start is ignored unless IDLE, abort drops to IDLE on the next edge.
// Ports   : cfg_* = table write and burst parameters, start/abort = control,
//           busy/done/tx_out = registered status and drive outputs.
module phased_tx_scheduler
   import phased_tx_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int DLY_W   = DLY_W_DEF,
   parameter int HALF_W  = HALF_W_DEF,
   parameter int PULSE_W = PULSE_W_DEF,
   localparam int AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [DLY_W-1:0]   cfg_wdata,
   input  logic [HALF_W-1:0]  cfg_half_period,
   input  logic [PULSE_W-1:0] cfg_num_pulses,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [NUM_CH-1:0]  tx_out
);

   localparam int TW = DLY_W + 1;

   state_e             state_q, state_d;
   logic [TW-1:0]      t_q, t_d;
   logic [HALF_W-1:0]  h_q, h_d;
   logic [PULSE_W-1:0] p_q, p_d;
   logic               busy_q, done_q;
   channel_cfg_t       shadow_q [NUM_CH];
   channel_cfg_t       active_q [NUM_CH];
   channel_cfg_t       active_d [NUM_CH];
   logic [NUM_CH-1:0]  fin;
   logic               go, kill;

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      h_d      = h_q;
      p_d      = p_q;
      active_d = active_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = (cfg_num_pulses == '0) ? ST_DONE : ST_ARM;
         ST_ARM: begin
            state_d  = abort ? ST_IDLE : ST_RUN;
            active_d = shadow_q;
            h_d      = (cfg_half_period == '0) ? HALF_W'(1) : cfg_half_period;
            p_d      = cfg_num_pulses;
            t_d      = '0;
         end
         ST_RUN: begin
            // abort outranks completion: an aborted burst never pulses done
            if (abort)     state_d = ST_IDLE;
            else if (&fin) state_d = ST_DONE;
            t_d = (t_q == '1) ? t_q : t_q + TW'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Channels are driven with next-cycle values so tx rises in the cycle where t==delay.
   assign go   = (state_d == ST_RUN);
   assign kill = abort && (state_q == ST_ARM || state_q == ST_RUN);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         t_q     <= '0;
         h_q     <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         h_q     <= h_d;
         p_q     <= p_d;
         busy_q  <= (state_d == ST_ARM) || (state_d == ST_RUN);
         done_q  <= (state_d == ST_DONE);
         for (int i = 0; i < NUM_CH; i++) begin
            // address decode per entry; addresses beyond NUM_CH-1 match nothing
            if (cfg_we && cfg_addr == AW'(i)) shadow_q[i].delay <= cfg_wdata;
            active_q[i] <= active_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      phased_tx_channel #(
         .DLY_W   (DLY_W),
         .HALF_W  (HALF_W),
         .PULSE_W (PULSE_W)
      ) u_ch (
         .clock    (clock),
         .reset    (reset),
         .go       (go),
         .t        (t_d),
         .delay    (active_d[g].delay),
         .H        (h_q),
         .P        (p_q),
         .kill     (kill),
         .tx       (tx_out[g]),
         .finished (fin[g])
      );
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_phased_tx_scheduler.sv
// Purpose : self-checking bench for phased_tx_scheduler against a cycle-indexed burst model.
// Latency : n/a.
// Backpressure : n/a.
module tb_phased_tx_scheduler;

   localparam int NCH = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [11:0] cfg_wdata;
   logic [11:0] cfg_half_period;
   logic [3:0]  cfg_num_pulses;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [7:0]  tx_out;

   always #5 clock = ~clock;

   phased_tx_scheduler dut (
      .clock           (clock),
      .reset           (reset),
      .cfg_we          (cfg_we),
      .cfg_addr        (cfg_addr),
      .cfg_wdata       (cfg_wdata),
      .cfg_half_period (cfg_half_period),
      .cfg_num_pulses  (cfg_num_pulses),
      .start           (start),
      .abort           (abort),
      .busy            (busy),
      .done            (done),
      .tx_out          (tx_out)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Burst model: a burst launched in cycle k runs from k+2; each channel is high
   // whenever (c - run_start - delay) lies in [0, 2HP) with an even half index.
   int sh [NCH];
   int m_d [NCH];
   bit m_have = 1'b0;
   int m_k, m_r, m_done, m_busy_last, m_end, m_h, m_p;
   int obs_k, obs_done;
   int obs_rise [NCH];
   int done_cnt;

   function automatic bit model_idle();
      return !m_have || cyc > m_end;
   endfunction

   function automatic bit exp_tx(int ch, int c);
      int rel;
      if (!m_have || c < m_r || c > m_busy_last) return 1'b0;
      rel = c - m_r - m_d[ch];
      return (rel >= 0) && (rel < 2 * m_h * m_p) && (((rel / m_h) % 2) == 0);
   endfunction

   task automatic launch(int c);
      int maxd;
      m_have = 1'b1;
      m_k    = c;
      obs_k  = c;
      obs_done = -1;
      for (int i = 0; i < NCH; i++) obs_rise[i] = -1;
      m_p = int'(cfg_num_pulses);
      m_h = (cfg_half_period == 0) ? 1 : int'(cfg_half_period);
      if (m_p == 0) begin
         m_r         = c + 1000000;
         m_busy_last = c;
         m_done      = c + 1;
         m_end       = c + 1;
      end else begin
         maxd = 0;
         for (int i = 0; i < NCH; i++) begin
            m_d[i] = sh[i];
            if (sh[i] > maxd) maxd = sh[i];
         end
         m_r         = c + 2;
         m_done      = m_r + maxd + 2 * m_h * m_p;
         m_busy_last = m_done - 1;
         m_end       = m_done;
      end
   endtask

   task automatic check_outputs();
      logic       eb, ed;
      logic [7:0] etx;
      eb = m_have && cyc >= m_k + 1 && cyc <= m_busy_last;
      ed = m_have && cyc == m_done;
      for (int i = 0; i < NCH; i++) etx[i] = exp_tx(i, cyc);
      checks++;
      if ({busy, done, tx_out} !== {eb, ed, etx}) begin
         errors++;
         $display("FAIL cycle %0d outputs: busy/done/tx got %b/%b/%b expected %b/%b/%b",
                  cyc, busy, done, tx_out, eb, ed, etx);
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (obs_done < 0) obs_done = cyc - obs_k;
      end
      for (int i = 0; i < NCH; i++)
         if (tx_out[i] === 1'b1 && obs_rise[i] < 0) obs_rise[i] = cyc - obs_k;
   endtask

   // Apply the current inputs to the model, advance one cycle, then check the DUT.
   task automatic tick();
      if (reset) begin
         m_have = 1'b0;
         for (int i = 0; i < NCH; i++) sh[i] = 0;
      end else begin
         if (cfg_we) sh[cfg_addr] = int'(cfg_wdata);
         if (model_idle() && start) launch(cyc);
         else if (m_have && abort && cyc >= m_k + 1 && cyc <= m_busy_last) begin
            m_busy_last = cyc;
            m_done      = -1;
            m_end       = cyc;
         end
      end
      @(negedge clock);
      cyc++;
      check_outputs();
   endtask

   task automatic check_val(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic program_delays(int step);
      cfg_we = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         cfg_addr  = 3'(i);
         cfg_wdata = 12'(i * step);
         tick();
      end
      cfg_we = 1'b0;
   endtask

   task automatic fire_and_run(int abort_off, int len);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int off = 1; off <= len; off++) begin
         abort = (off == abort_off);
         tick();
      end
      abort = 1'b0;
   endtask

   typedef struct {
      int step;
      int h;
      int p;
      int abort_off;
      int exp_done;
      int exp_rise7;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{step: 2, h: 3, p: 2, abort_off: -1, exp_done: 28, exp_rise7: 16};
      tbl[1] = '{step: 0, h: 1, p: 1, abort_off: -1, exp_done: 4,  exp_rise7: 2};
      tbl[2] = '{step: 1, h: 2, p: 3, abort_off: -1, exp_done: 21, exp_rise7: 9};
      tbl[3] = '{step: 3, h: 0, p: 1, abort_off: -1, exp_done: 25, exp_rise7: 23};
      tbl[4] = '{step: 2, h: 3, p: 0, abort_off: -1, exp_done: 1,  exp_rise7: -1};
      tbl[5] = '{step: 2, h: 3, p: 2, abort_off: 6,  exp_done: -1, exp_rise7: -1};

      for (int i = 0; i < NCH; i++) sh[i] = 0;
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      cfg_half_period = '0; cfg_num_pulses = '0; start = 1'b0; abort = 1'b0;
      done_cnt = 0;
      tick();
      tick();
      reset = 1'b0;
      repeat (20) tick();

      for (int v = 0; v < 6; v++) begin
         program_delays(tbl[v].step);
         cfg_half_period = 12'(tbl[v].h);
         cfg_num_pulses  = 4'(tbl[v].p);
         fire_and_run(tbl[v].abort_off, 40);
         check_val($sformatf("vec%0d done offset", v), obs_done, tbl[v].exp_done);
         check_val($sformatf("vec%0d ch7 rise offset", v), obs_rise[7], tbl[v].exp_rise7);
      end

      // Abort at k+6 then restart in the very next cycle: full burst again.
      fire_and_run(6, 6);
      fire_and_run(-1, 40);
      check_val("restart done offset", obs_done, 28);
      check_val("restart ch0 rise offset", obs_rise[0], 2);

      // Rewrite ch3 mid-burst: current burst keeps delay 6, next uses 5.
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 12'd5;
      tick();
      cfg_we = 1'b0;
      repeat (36) tick();
      check_val("old ch3 rise offset", obs_rise[3], 8);
      fire_and_run(-1, 40);
      check_val("new ch3 rise offset", obs_rise[3], 7);

      // Start held high with H=0, P=1: one burst every 19 cycles, never overlapping.
      program_delays(2);
      cfg_half_period = 12'd0;
      cfg_num_pulses  = 4'd1;
      done_cnt = 0;
      start = 1'b1;
      repeat (61) tick();
      start = 1'b0;
      check_val("held-start done count", done_cnt, 3);
      repeat (25) tick();

      // Reset mid-burst clears outputs and tables: all-zero delays give done at k+4.
      cfg_half_period = 12'd3;
      cfg_num_pulses  = 4'd2;
      start = 1'b1; tick(); start = 1'b0;
      repeat (8) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      tick();
      cfg_half_period = 12'd1;
      cfg_num_pulses  = 4'd1;
      fire_and_run(-1, 10);
      check_val("post-reset done offset", obs_done, 4);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         cfg_we    = ($urandom % 10) == 0;
         cfg_addr  = 3'($urandom);
         cfg_wdata = 12'($urandom_range(0, 12));
         start     = ($urandom % 6) == 0;
         abort     = ($urandom % 30) == 0;
         if (model_idle() && !start && ($urandom % 4) == 0) begin
            cfg_half_period = 12'($urandom_range(0, 3));
            cfg_num_pulses  = 4'($urandom_range(0, 3));
         end
         tick();
      end
      start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      repeat (120) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
